// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 iteration per cycle; start -> result in 33 edges, done pulses in the following cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] input1,
   input  logic [31:0] input2,
   input  logic        hiWe,
   input  logic        loWe,
   input  logic [31:0] wrData,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t      r_state, w_next;
   logic        r_busy, r_done;
   logic        r_is_div, r_div0, r_neg_res, r_neg_rem;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;

   logic        w_signed_in;
   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_madd, w_rshift, w_rdiff;
   logic        w_qbit;
   logic [63:0] w_prod_fix;
   logic [31:0] w_q, w_r, w_hi_res, w_lo_res;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Signed ops (MULT, DIV) have op[0] == 0; operands are iterated as magnitudes.
   assign w_signed_in = ~op[0];
   assign w_a_mag     = (w_signed_in && input1[31]) ? (~input1 + 32'd1) : input1;
   assign w_b_mag     = (w_signed_in && input2[31]) ? (~input2 + 32'd1) : input2;

   assign w_madd   = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);
   assign w_rshift = {r_acc[63:32], r_a[31]};
   assign w_rdiff  = w_rshift - {1'b0, r_b};
   assign w_qbit   = ~w_rdiff[32];

   // A zero divisor never borrows, so the quotient saturates to all ones and the
   // remainder ends as the dividend magnitude; re-signing it restores input1.
   assign w_prod_fix = r_neg_res ? (~r_acc + 64'd1) : r_acc;
   assign w_q        = r_acc[31:0];
   assign w_r        = r_acc[63:32];
   assign w_lo_res   = r_is_div ? (r_div0 ? 32'hFFFF_FFFF : (r_neg_res ? (~w_q + 32'd1) : w_q))
                                : w_prod_fix[31:0];
   assign w_hi_res   = r_is_div ? (r_neg_rem ? (~w_r + 32'd1) : w_r) : w_prod_fix[63:32];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_is_div  <= 1'b0;
         r_div0    <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_div  <= op[1];
                  r_div0    <= (input2 == 32'd0);
                  r_neg_res <= w_signed_in && (input1[31] ^ input2[31]);
                  r_neg_rem <= w_signed_in && op[1] && input1[31];
                  r_a       <= w_a_mag;
                  r_b       <= w_b_mag;
                  r_acc     <= '0;
                  r_cnt     <= '0;
               end else begin
                  if (hiWe) r_hi <= wrData;
                  if (loWe) r_lo <= wrData;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_is_div) begin
                  r_acc <= {(w_qbit ? w_rdiff[31:0] : w_rshift[31:0]), r_acc[30:0], w_qbit};
                  r_a   <= {r_a[30:0], 1'b0};
               end else begin
                  r_acc <= {w_madd, r_acc[31:1]};
                  r_b   <= {1'b0, r_b[31:1]};
               end
            end
            S_FIX: begin
               r_hi <= w_hi_res;
               r_lo <= w_lo_res;
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scenario tasks with a scoreboard queue of
// expected {hi,lo} values computed by a behavioural model.
module tb_mult_div_unit;

   logic        clk, resetN, start, hiWe, loWe;
   logic [1:0]  op;
   logic [31:0] input1, input2, wrData;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic [1:0]  o_dbg_state;

   logic [63:0] exp_q[$];
   logic [63:0] last_res;
   int          tests, fails;

   mult_div_unit dut (
      .clk(clk), .resetN(resetN), .start(start), .op(op),
      .input1(input1), .input2(input2), .hiWe(hiWe), .loWe(loWe),
      .wrData(wrData), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .o_dbg_state(o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      int sa, sb;
      case (o)
         2'd0: begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
            return ea * eb;
         end
         2'd1: return {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Drives start for one cycle from the current negedge and records the expectation.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      op     = o;
      input1 = a;
      input2 = b;
      exp_q.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int bc, output bit seen);
      int n;
      bc = 0;
      n  = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         n++;
      end
      seen = (done === 1'b1);
   endtask

   task automatic test_reset;
      resetN = 1'b0; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      op = 2'd0; input1 = '0; input2 = '0; wrData = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy, done, hi, lo, o_dbg_state} !== 68'd0) begin
         fails++;
         $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h st=%0d want all 0",
                  busy, done, hi, lo, o_dbg_state);
      end
      resetN = 1'b1;
      last_res = 64'd0;
      @(negedge clk);
   endtask

   task automatic test_multu_latency;
      int bc; bit seen; logic [63:0] e;
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen) begin fails++; $display("FAIL multu_done: done not seen within 40 cycles"); end
      tests++;
      if (bc != 33) begin fails++; $display("FAIL multu_busy_len: got %0d cycles want 33", bc); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
      tests++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || {hi, lo} !== e) begin
         fails++; $display("FAIL multu_result: got %h_%h want %h", hi, lo, e);
      end
      last_res = e;
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse: done still %b want 0", done); end
   endtask

   task automatic test_signed;
      int bc; bit seen; logic [63:0] e;
      issue(2'd0, 32'hFFFF_FFFD, 32'd7);
      repeat (5) @(negedge clk);
      tests++;
      if ({hi, lo} !== last_res) begin
         fails++; $display("FAIL hold_during_run: got %h_%h want %h", hi, lo, last_res);
      end
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || {hi, lo} !== e) begin
         fails++; $display("FAIL mult_neg: got %h_%h want %h", hi, lo, e);
      end
      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || {hi, lo} !== e) begin
         fails++; $display("FAIL div_neg: got %h_%h want %h", hi, lo, e);
      end
      last_res = e;
   endtask

   task automatic test_div_corner;
      int bc; bit seen; logic [63:0] e;
      issue(2'd3, 32'd100, 32'd0);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || bc != 33 || {hi, lo} !== 64'h0000_0064_FFFF_FFFF || {hi, lo} !== e) begin
         fails++; $display("FAIL divu_by_zero: got %h_%h busy=%0d want %h busy=33", hi, lo, bc, e);
      end
      issue(2'd2, 32'hFFFF_FFF0, 32'd0);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'hFFFF_FFF0_FFFF_FFFF || {hi, lo} !== e) begin
         fails++; $display("FAIL div_by_zero_neg: got %h_%h want %h", hi, lo, e);
      end
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'h0000_0000_8000_0000 || {hi, lo} !== e) begin
         fails++; $display("FAIL div_overflow: got %h_%h want %h", hi, lo, e);
      end
      last_res = e;
   endtask

   task automatic test_mt_writes;
      int bc; bit seen; logic [63:0] e;
      hiWe = 1'b1; wrData = 32'h1234_5678;
      @(negedge clk);
      hiWe = 1'b0; loWe = 1'b1; wrData = 32'h9ABC_DEF0;
      tests++;
      if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi: got %h want 12345678", hi); end
      @(negedge clk);
      loWe = 1'b0;
      tests++;
      if (lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo: got %h want 9abcdef0", lo); end
      hiWe = 1'b1; wrData = 32'hDEAD_BEEF;
      issue(2'd1, 32'd2, 32'd3);
      hiWe = 1'b0;
      tests++;
      if (hi !== 32'h1234_5678 || busy !== 1'b1) begin
         fails++; $display("FAIL start_beats_mthi: got hi=%h busy=%b want 12345678 busy=1", hi, busy);
      end
      repeat (4) @(negedge clk);
      hiWe = 1'b1; loWe = 1'b1; wrData = 32'hCAFE_BABE;
      @(negedge clk);
      hiWe = 1'b0; loWe = 1'b0;
      tests++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
         fails++; $display("FAIL mt_during_run: got %h_%h want 12345678_9abcdef0", hi, lo);
      end
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'd6 || {hi, lo} !== e) begin
         fails++; $display("FAIL mt_then_multu: got %h_%h want %h", hi, lo, e);
      end
      last_res = e;
   endtask

   task automatic test_back_to_back;
      int bc; bit seen; logic [63:0] e;
      issue(2'd1, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      start = 1'b1; op = 2'd3; input1 = 32'd9; input2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || {hi, lo} !== 64'd30 || {hi, lo} !== e) begin
         fails++; $display("FAIL start_while_busy: got %h_%h want %h", hi, lo, e);
      end
      issue(2'd3, 32'd9, 32'd3);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || bc != 33 || {hi, lo} !== 64'd3 || {hi, lo} !== e) begin
         fails++; $display("FAIL back_to_back: got %h_%h busy=%0d want %h busy=33", hi, lo, bc, e);
      end
      last_res = e;
   endtask

   task automatic test_random;
      int bc; bit seen; logic [63:0] e;
      logic [1:0] o; logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         if (i == 1) b = b >> $urandom_range(16, 31);
         issue(o, a, b);
         wait_done(bc, seen);
         e = exp_q.pop_front();
         tests++;
         if (!seen || {hi, lo} !== e) begin
            fails++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h_%h want %h", i, o, a, b, hi, lo, e);
         end
         last_res = e;
      end
   endtask

   task automatic test_reset_mid_op;
      int bc; bit seen; logic [63:0] e;
      issue(2'd3, 32'd1000, 32'd7);
      repeat (14) @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      tests++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         fails++; $display("FAIL async_abort: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
      end
      exp_q.delete();
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      issue(2'd1, 32'd2, 32'd3);
      wait_done(bc, seen);
      e = exp_q.pop_front();
      tests++;
      if (!seen || bc != 33 || {hi, lo} !== 64'd6 || {hi, lo} !== e) begin
         fails++; $display("FAIL after_reset: got %h_%h busy=%0d want %h busy=33", hi, lo, bc, e);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_multu_latency();
      test_signed();
      test_div_corner();
      test_mt_writes();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
